pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter CNT_BITS, default 8: width of the length input and the internal pulse counter.
REQ-002 SHALL have parameter HOLDOFF, default 2: cycles (0..255) of mandatory idle after each pulse.
REQ-003 SHALL have port clk, input, 1: single clock; all flops on posedge clk.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port din, input, 1: strobe to be stretched, fed by the dout of a shift_register delay stage.
REQ-006 SHALL have port len, input, CNT_BITS: requested pulse length in cycles.
REQ-007 SHALL have port clr_missed, input, 1: one-cycle clear of missed_cnt.
REQ-008 SHALL have port dout, output, 1: stretched pulse, registered.
REQ-009 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-010 SHALL have port missed_cnt, output, 8: saturating count of dropped edges.

Function
REQ-011 SHALL register din into din_d every cycle, regardless of state; edge = din & ~din_d.
REQ-012 SHALL implement states IDLE, PULSE and HOLDOFF.
REQ-013 SHALL, in IDLE on edge: go to PULSE, set dout=1 and load cnt = max(len,1)-1; len==0 is treated as 1.
REQ-014 SHALL hold dout high for exactly max(len,1) cycles, starting the cycle after the clock that sampled the edge (latency 1).
REQ-015 SHALL, in PULSE with cnt!=0, decrement cnt; with cnt==0, clear dout and go to HOLDOFF (loading cnt=HOLDOFF-1), or to IDLE if HOLDOFF==0.
REQ-016 SHALL, in HOLDOFF, decrement cnt and go to IDLE when cnt==0; busy stays high throughout.
REQ-017 SHALL drop any edge occurring in HOLDOFF, including the HOLDOFF->IDLE cycle, and increment missed_cnt.
REQ-018 SHALL ignore len changes during PULSE and HOLDOFF; len is sampled only at the accepting edge.
REQ-019 SHALL saturate missed_cnt at 255.
REQ-020 SHALL, on clr_missed coinciding with a drop, set missed_cnt to 1; clr_missed alone sets it to 0.

Reset
REQ-021 SHALL, on reset_n low, asynchronously force state=IDLE, dout=0, busy=0, cnt=0 and missed_cnt=0.
REQ-022 SHALL reset din_d to 1, so din already high at reset release produces no edge.
REQ-023 SHALL let a reset asserted mid-pulse drop dout within the same cycle, with no completion of the pulse.

Configuration
REQ-024 SHALL, with PULSE_STRETCHER_RETRIGGER_EN defined, treat an edge in PULSE (including the cnt==0 cycle) as a retrigger: reload cnt=max(len,1)-1, keep dout high, do not count it as missed.
REQ-025 SHALL, without PULSE_STRETCHER_RETRIGGER_EN, drop an edge in PULSE and increment missed_cnt.

Structure
REQ-026 SHALL place the state encoding (IDLE=0, PULSE=1, HOLDOFF=2) and the missed-counter width constant (8) in shared package pulse_stretcher_pkg.
REQ-027 SHALL use one sub-module, edge_detector (din, din_d register, edge out, reset value 1); the FSM and counters stay in pulse_stretcher.

Verification
REQ-028 SHALL cover: len=3, HOLDOFF=2, a single 1-cycle din pulse -> dout high exactly 3 cycles starting 1 cycle after the sampling edge; busy high 5 cycles; missed_cnt=0.
REQ-029 SHALL cover: len=0, single edge -> dout high exactly 1 cycle.
REQ-030 SHALL cover: len=4, a second edge 2 cycles into the pulse -> without the macro, dout high 4 cycles and missed_cnt=1; with the macro, dout high 6 cycles total and missed_cnt=0.
REQ-031 SHALL cover: din held high across reset release -> no pulse; then din low 1 cycle and high again -> one pulse.
REQ-032 SHALL cover: 300 edges presented during HOLDOFF windows -> missed_cnt=255; then clr_missed coinciding with a drop -> missed_cnt=1.
REQ-033 SHALL cover: reset_n pulled low in cycle 2 of a len=5 pulse -> dout=0 immediately; the next edge after release gives a full 5-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and counter constants for pulse_stretcher
// Contents:
//   state_e      : FSM state encoding (ST_IDLE=0, ST_PULSE=1, ST_HOLDOFF=2)
//   MISSED_W     : width of the saturating missed-edge counter
//   MISSED_MAX   : saturation value of the missed-edge counter
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    localparam int MISSED_W = 8;
    localparam logic [MISSED_W-1:0] MISSED_MAX = {MISSED_W{1'b1}};

endpackage : pulse_stretcher_pkg

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - signal bundle between a strobe source and pulse_stretcher
// Signals:
//   din        : strobe to be stretched (source -> stretcher)
//   len        : requested pulse length in cycles (source -> stretcher)
//   clr_missed : one-cycle clear of missed_cnt (source -> stretcher)
//   dout       : stretched pulse (stretcher -> source)
//   busy       : stretcher not idle (stretcher -> source)
//   missed_cnt : saturating count of dropped edges (stretcher -> source)
// Modports: master (drives din/len/clr_missed), slave (the stretcher).
interface pulse_stretcher_if
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_BITS = 8
) ();

    logic                din;
    logic [CNT_BITS-1:0] len;
    logic                clr_missed;
    logic                dout;
    logic                busy;
    logic [MISSED_W-1:0] missed_cnt;

    modport master (
        output din,
        output len,
        output clr_missed,
        input  dout,
        input  busy,
        input  missed_cnt
    );

    modport slave (
        input  din,
        input  len,
        input  clr_missed,
        output dout,
        output busy,
        output missed_cnt
    );

endinterface : pulse_stretcher_if

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - rising-edge detector with a delayed copy of din
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   din     : synchronous strobe input
//   rise    : din & ~din_d, combinational
// The delay flop resets to 1 so a din already high when reset releases
// is not mistaken for a fresh edge.
module edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_d_q;
    logic din_d_d;

    always_comb begin
        din_d_d = din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_d_q <= 1'b1;
        end else begin
            din_d_q <= din_d_d;
        end
    end

    assign rise = din & ~din_d_q;

endmodule : edge_detector

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches a strobe edge into a len-cycle pulse followed by a holdoff gap
// Parameters:
//   CNT_BITS : width of len and the internal pulse counter
//   HOLDOFF  : idle cycles (0..255) enforced after each pulse
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pulse_stretcher_if.slave (din, len, clr_missed in; dout, busy, missed_cnt out)
// Build option: PULSE_STRETCHER_RETRIGGER_EN - an edge during the pulse
// restarts the length count instead of being dropped.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_BITS = 8,
    parameter int HOLDOFF  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    pulse_stretcher_if.slave   bus
);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    localparam logic [CNT_BITS-1:0] HOLDOFF_LOAD =
        (HOLDOFF == 0) ? '0 : CNT_BITS'(HOLDOFF - 1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                dout_q, dout_d;
    logic                busy_q, busy_d;
    logic [MISSED_W-1:0] missed_q, missed_d;

    logic                rise;
    logic                drop;
    logic [CNT_BITS-1:0] pulse_load;

    edge_detector u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.din),
        .rise    (rise)
    );

    // max(len,1)-1: a zero length still yields a one-cycle pulse
    assign pulse_load = (bus.len == '0) ? '0 : bus.len - CNT_BITS'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        drop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PULSE;
                    dout_d  = 1'b1;
                    cnt_d   = pulse_load;
                end
            end

            ST_PULSE: begin
                // Retrigger wins even on the last pulse cycle, so the pulse
                // continues seamlessly instead of dropping for a cycle.
                if (rise && RETRIG_EN) begin
                    cnt_d  = pulse_load;
                    dout_d = 1'b1;
                end else begin
                    drop = rise;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end else begin
                        dout_d = 1'b0;
                        if (HOLDOFF == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLDOFF_LOAD;
                        end
                    end
                end
            end

            ST_HOLDOFF: begin
                // Edges here are lost, including the cycle that returns to IDLE.
                drop = rise;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // A clear that coincides with a drop keeps that drop counted.
    always_comb begin
        missed_d = missed_q;
        if (bus.clr_missed) begin
            missed_d = drop ? MISSED_W'(1) : '0;
        end else if (drop && (missed_q != MISSED_MAX)) begin
            missed_d = missed_q + MISSED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            missed_q <= missed_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.missed_cnt = missed_q;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

    logic clk;
    logic reset_n;
    int   assert_cnt;
    int   fail_cnt;

    pulse_stretcher_if #(.CNT_BITS(8)) bus ();

    pulse_stretcher #(
        .CNT_BITS (8),
        .HOLDOFF  (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave the bench 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle din pulse with length lv; len switches to len_after right
    // after the accepting edge. Counts dout/busy high cycles from the first
    // cycle after the sampling edge.
    task automatic run_pulse(input string tag, input logic [7:0] lv, input logic [7:0] len_after,
                             input int exp_hi, input int exp_busy);
        int hi;
        int bz;
        check({tag, "_pre"}, 32'(bus.dout), 32'd0);
        bus.len = lv;
        bus.din = 1'b1;
        step();
        check({tag, "_lat"}, 32'(bus.dout), 32'd1);
        bus.din = 1'b0;
        bus.len = len_after;
        hi = 0;
        bz = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(bus.dout);
            bz += int'(bus.busy);
            step();
        end
        check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
        check({tag, "_busy"}, 32'(bz), 32'(exp_busy));
    endtask

    initial begin
        int hi;
        assert_cnt     = 0;
        fail_cnt       = 0;
        reset_n        = 1'b0;
        bus.din        = 1'b1;
        bus.len        = 8'd3;
        bus.clr_missed = 1'b0;

        // Reset with din held high
        step();
        step();
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_missed", 32'(bus.missed_cnt), 32'd0);
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            hi += int'(bus.dout) + int'(bus.busy);
        end
        check("high_at_release_no_pulse", 32'(hi), 32'd0);
        bus.din = 1'b0;
        step();
        run_pulse("rearm", 8'd3, 8'd3, 3, 5);

        // Basic len=3 pulse, HOLDOFF=2
        run_pulse("len3", 8'd3, 8'd3, 3, 5);
        check("len3_missed", 32'(bus.missed_cnt), 32'd0);

        // len=0 behaves as 1
        run_pulse("len0", 8'd0, 8'd0, 1, 3);

        // len change after acceptance is ignored
        run_pulse("len_ignore", 8'd2, 8'd7, 2, 4);

        // Second edge two cycles into a len=4 pulse
        bus.len = 8'd4;
        bus.din = 1'b1;
        hi = 0;
        step();
        hi += int'(bus.dout);
        bus.din = 1'b0;
        step();
        hi += int'(bus.dout);
        bus.din = 1'b1;
        step();
        hi += int'(bus.dout);
        bus.din = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi += int'(bus.dout);
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        check("retrig_hi", 32'(hi), 32'd6);
        check("retrig_missed", 32'(bus.missed_cnt), 32'd0);
`else
        check("pulse_edge_hi", 32'(hi), 32'd4);
        check("pulse_edge_missed", 32'(bus.missed_cnt), 32'd1);
`endif
        bus.clr_missed = 1'b1;
        step();
        bus.clr_missed = 1'b0;
        check("clr_alone", 32'(bus.missed_cnt), 32'd0);

        // Edges landing in HOLDOFF: pattern 1,0,1,0 with len=1 drops one per period
        bus.len = 8'd1;
        for (int n = 1; n <= 300; n++) begin
            bus.din = 1'b1; step();
            bus.din = 1'b0; step();
            bus.din = 1'b1; step();
            bus.din = 1'b0; step();
            if (n == 100) check("missed_100", 32'(bus.missed_cnt), 32'd100);
            if (n == 255) check("missed_255", 32'(bus.missed_cnt), 32'd255);
        end
        check("missed_sat", 32'(bus.missed_cnt), 32'd255);

        // Clear coinciding with a drop
        bus.din = 1'b1; step();
        bus.din = 1'b0; step();
        bus.din = 1'b1; bus.clr_missed = 1'b1; step();
        bus.din = 1'b0; bus.clr_missed = 1'b0; step();
        check("clr_with_drop", 32'(bus.missed_cnt), 32'd1);
        step();
        step();

        // Reset in cycle 2 of a len=5 pulse
        bus.len = 8'd5;
        bus.din = 1'b1;
        step();
        check("rst_mid_lat", 32'(bus.dout), 32'd1);
        bus.din = 1'b0;
        step();
        check("rst_mid_cycle2", 32'(bus.dout), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_dout", 32'(bus.dout), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_missed", 32'(bus.missed_cnt), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            hi += int'(bus.dout);
        end
        check("rst_mid_no_resume", 32'(hi), 32'd0);
        run_pulse("post_rst", 8'd5, 8'd5, 5, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_pulse_stretcher
